// File: rtl/mc10_arb_pkg.sv
// Shared types and defaults for the MC-10 single-port RAM arbiter.
// The optional ARB_RR_EN build switch changes only the IDLE tie-break.
package mc10_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } arb_owner_t;

endpackage

// File: rtl/mc10_arb_pick.sv
// Grant selection between CPU and video requesters; excl_owner masks out the
// requester that currently holds the RAM. ARB_RR_EN selects round-robin ties.
module mc10_arb_pick
    import mc10_arb_pkg::*;
(
    input  logic       cpu_req,
    input  logic       vid_req,
    input  logic [1:0] last_owner,
    input  logic [1:0] excl_owner,
    output logic [1:0] grant
);

    logic cpu_ok;
    logic vid_ok;

    assign cpu_ok = cpu_req && (excl_owner != OWN_CPU);
    assign vid_ok = vid_req && (excl_owner != OWN_VID);

`ifndef ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = ^last_owner;
`endif

    always_comb begin
        grant = OWN_NONE;
        if (cpu_ok && vid_ok) begin
`ifdef ARB_RR_EN
            grant = (last_owner == OWN_VID) ? OWN_CPU : OWN_VID;
`else
            // Display fetches have a hard deadline, so video wins ties.
            grant = OWN_VID;
`endif
        end else if (cpu_ok) begin
            grant = OWN_CPU;
        end else if (vid_ok) begin
            grant = OWN_VID;
        end
    end

endmodule

// File: rtl/mc10_ram_arbiter.sv
// Shares one single-port synchronous RAM between the CPU bus and the VDG fetcher.
// Define ARB_RR_EN for round-robin tie-break in IDLE (default: video priority).
module mc10_ram_arbiter
    import mc10_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk_4,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    arb_state_t    state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [1:0]    grant;
    logic [1:0]    excl_owner;
    logic [1:0]    last_owner;
    logic          take_grant;
    logic          we_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] vid_rdata_q;

`ifdef ARB_RR_EN
    logic [1:0] last_owner_q;
    assign last_owner = last_owner_q;
`else
    assign last_owner = OWN_CPU;
`endif

    // In DATA the current owner is masked so the other side gets the handoff.
    assign excl_owner = (state_q == ST_DATA) ? owner_q : OWN_NONE;

    mc10_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .vid_req    (vid_req),
        .last_owner (last_owner),
        .excl_owner (excl_owner),
        .grant      (grant)
    );

    always_ff @(posedge clk_4) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            we_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
`ifdef ARB_RR_EN
            last_owner_q <= OWN_CPU;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (take_grant) begin
                ram_addr_q <= (grant == OWN_CPU) ? cpu_addr : vid_addr;
                we_q       <= (grant == OWN_CPU) && cpu_we;
                if (grant == OWN_CPU) begin
                    ram_wdata_q <= cpu_wdata;
                end
            end
            if ((state_q == ST_DATA) && !we_q) begin
                if (owner_q == OWN_CPU) begin
                    cpu_rdata_q <= ram_rdata;
                end
                if (owner_q == OWN_VID) begin
                    vid_rdata_q <= ram_rdata;
                end
            end
`ifdef ARB_RR_EN
            // Only IDLE grants feed the tie-break history; DATA handoffs are forced.
            if ((state_q == ST_IDLE) && take_grant) begin
                last_owner_q <= grant;
            end
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        take_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant != OWN_NONE) begin
                    state_d    = ST_ISSUE;
                    owner_d    = grant;
                    take_grant = 1'b1;
                end
            end
            ST_ISSUE: begin
                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (grant != OWN_NONE) begin
                    state_d    = ST_ISSUE;
                    owner_d    = grant;
                    take_grant = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_comb begin
        cpu_ack   = (state_q == ST_DATA) && (owner_q == OWN_CPU);
        vid_ack   = (state_q == ST_DATA) && (owner_q == OWN_VID);
        ram_we    = (state_q == ST_ISSUE) && (owner_q == OWN_CPU) && we_q;
        busy      = (state_q != ST_IDLE);
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        cpu_rdata = cpu_rdata_q;
        vid_rdata = vid_rdata_q;
    end

endmodule
